// File: rtl/ula_seq_ctrl.sv
// Multi-cycle ALU: one 74181-style 4-bit slice stepped over the operand nibbles, LSB first.
// Optional `ULA_SEQ_ZERO_FLAG_EN adds a registered zero flag output.
module ula_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             a_eq_b,
  output logic             c_out
`ifdef ULA_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, f_q, f_d;
  logic [3:0]       s_q;
  logic             m_q, carry_q, eq_q;
  logic [IdxW-1:0]  idx_q;
  logic [IdxW+1:0]  base;

  logic [3:0] nib_a, nib_b, t1, t2, slice_f;
  logic [4:0] slice_sum;
  logic       slice_cout, slice_eq;

  // Slice: F is the sum (arith) or inverted half-sum (logic) of two select-gated terms.
  // Carry out is active-low like the carry in and is produced in both modes.
  always_comb begin
    base      = {idx_q, 2'b00};
    nib_a     = a_q[base +: 4];
    nib_b     = b_q[base +: 4];
    t1        = nib_a | (nib_b & {4{s_q[0]}}) | (~nib_b & {4{s_q[1]}});
    t2        = (nib_a & ~nib_b & {4{s_q[2]}}) | (nib_a & nib_b & {4{s_q[3]}});
    slice_sum = {1'b0, t1} + {1'b0, t2} + {4'b0000, ~carry_q};
    slice_f   = m_q ? ~(t1 ^ t2) : slice_sum[3:0];
    slice_cout = ~slice_sum[4];
    slice_eq  = &slice_f;
  end

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StCalc;
      StCalc: begin
        f_d[base +: 4] = slice_f;
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      if (state_q == StIdle && in_valid) begin
        a_q     <= a;
        b_q     <= b;
        s_q     <= s;
        m_q     <= m;
        carry_q <= c_in;
        eq_q    <= 1'b1;
        idx_q   <= '0;
      end else if (state_q == StCalc) begin
        carry_q <= slice_cout;
        eq_q    <= eq_q & slice_eq;
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic zero_q;

  // Captured on the final pass so it appears together with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (state_q == StCalc && idx_q == LastIdx) begin
      zero_q <= (f_d == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign f         = f_q;
  assign a_eq_b    = eq_q;
  assign c_out     = carry_q;

endmodule
